// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the MIPS-subset control path: FSM state encoding,
// Op/Func codes, Aluc/Pcsrc encodings, the instruction-class enum and the
// bundled decode-output record used by both the decoder and the FSM.
// -----------------------------------------------------------------------------
package ctrl_pkg;

  // FSM states; the numeric values are visible on the State debug port.
  typedef enum logic [2:0] {
    ST_RST = 3'd0,
    ST_IF  = 3'd1,
    ST_ID  = 3'd2,
    ST_EX  = 3'd3,
    ST_MEM = 3'd4,
    ST_WB  = 3'd5
  } state_e;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef enum logic [1:0] {
    ALUC_ADD = 2'b00,
    ALUC_SUB = 2'b01,
    ALUC_AND = 2'b10,
    ALUC_OR  = 2'b11
  } aluc_e;

  // 2'b11 is unused.
  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_JUMP   = 2'b01,
    PCSRC_BRANCH = 2'b10
  } pcsrc_e;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_RALU,
    CLS_IALU,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_ILL
  } instr_class_e;

  // Everything the datapath needs from one decoded instruction.
  typedef struct packed {
    instr_class_e cls;
    logic         regrt;
    logic         se;
    logic         aluqb;
    aluc_e        aluc;
    logic         reg2reg;
  } dec_t;

  function automatic dec_t mk_dec(input instr_class_e cls,
                                  input logic         regrt,
                                  input logic         se,
                                  input logic         aluqb,
                                  input aluc_e        aluc,
                                  input logic         reg2reg);
    dec_t d;
    d.cls     = cls;
    d.regrt   = regrt;
    d.se      = se;
    d.aluqb   = aluqb;
    d.aluc    = aluc;
    d.reg2reg = reg2reg;
    return d;
  endfunction

  localparam dec_t DEC_NONE = '{cls: CLS_NONE, regrt: 1'b0, se: 1'b0,
                                aluqb: 1'b0, aluc: ALUC_ADD, reg2reg: 1'b0};

endpackage

// File: rtl/instr_class_dec.sv
// -----------------------------------------------------------------------------
// instr_class_dec
// Purely combinational Op/Func decoder: classifies the instruction and
// produces the datapath decode fields (Regrt, Se, Aluqb, Aluc, Reg2reg).
// Kept standalone so a pipelined control unit can reuse it unchanged.
//
// Ports:
//   i_op   [5:0]  opcode field
//   i_func [5:0]  function field (meaningful only for Op = 0)
//   o_dec         class plus decode fields; unknown encodings give CLS_ILL
//                 with every decode field cleared
// -----------------------------------------------------------------------------
module instr_class_dec
  import ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output dec_t       o_dec
);

  always_comb begin
    // NOTE: a default is assigned before the case so every path drives
    // o_dec; a missing branch would otherwise infer a latch.
    o_dec = mk_dec(CLS_ILL, 1'b0, 1'b0, 1'b0, ALUC_ADD, 1'b0);
    unique case (i_op)
      OP_RTYPE: begin
        case (i_func)
          FN_ADD:  o_dec = mk_dec(CLS_RALU, 1'b0, 1'b0, 1'b1, ALUC_ADD, 1'b1);
          FN_SUB:  o_dec = mk_dec(CLS_RALU, 1'b0, 1'b0, 1'b1, ALUC_SUB, 1'b1);
          FN_AND:  o_dec = mk_dec(CLS_RALU, 1'b0, 1'b0, 1'b1, ALUC_AND, 1'b1);
          FN_OR:   o_dec = mk_dec(CLS_RALU, 1'b0, 1'b0, 1'b1, ALUC_OR,  1'b1);
          default: ;
        endcase
      end
      OP_ADDI: o_dec = mk_dec(CLS_IALU, 1'b1, 1'b1, 1'b0, ALUC_ADD, 1'b1);
      // Logical immediates are zero-extended.
      OP_ANDI: o_dec = mk_dec(CLS_IALU, 1'b1, 1'b0, 1'b0, ALUC_AND, 1'b1);
      OP_ORI:  o_dec = mk_dec(CLS_IALU, 1'b1, 1'b0, 1'b0, ALUC_OR,  1'b1);
      OP_LW:   o_dec = mk_dec(CLS_LW,   1'b1, 1'b1, 1'b0, ALUC_ADD, 1'b0);
      OP_SW:   o_dec = mk_dec(CLS_SW,   1'b1, 1'b1, 1'b0, ALUC_ADD, 1'b0);
      // Branches compare rs - rt, so B comes from the register file.
      OP_BEQ:  o_dec = mk_dec(CLS_BEQ,  1'b1, 1'b1, 1'b1, ALUC_SUB, 1'b0);
      OP_BNE:  o_dec = mk_dec(CLS_BNE,  1'b1, 1'b1, 1'b1, ALUC_SUB, 1'b0);
      OP_J:    o_dec = mk_dec(CLS_J,    1'b0, 1'b0, 1'b0, ALUC_ADD, 1'b0);
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
// Multi-cycle control FSM for the MIPS-subset datapath. Sequences one
// instruction at a time through IF/ID/EX/MEM/WB with variable-latency
// instruction/data memory handshakes, a per-wait timeout, a sticky
// illegal-opcode flag and a retired-instruction counter.
//
// Parameters:
//   TIMEOUT  max cycles a memory request waits for rdy before abort (>= 2)
//   CNT_W    width of the retired-instruction counter
//
// Ports:
//   Clk, Rst           clock (rising edge), synchronous active-high reset
//   Op, Func, Z        IR fields and ALU zero flag
//   Imem_rdy, Dmem_rdy memory handshake completion
//   Imem_req, Dmem_req memory requests
//   Pcwr, Irwr, Pcsrc  PC / IR write strobes and PC source select
//   Regrt, Se, Aluqb, Aluc, Reg2reg, Wreg, Wmem   datapath controls
//   Instr_done         pulse on the last cycle of each legal instruction
//   Icount             retired legal instructions (wraps)
//   Illegal, Err       sticky illegal-decode / memory-timeout flags
//   State              debug view of the FSM state
// -----------------------------------------------------------------------------
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  input  logic             Z,
  input  logic             Imem_rdy,
  input  logic             Dmem_rdy,
  output logic             Imem_req,
  output logic             Dmem_req,
  output logic             Pcwr,
  output logic             Irwr,
  output logic [1:0]       Pcsrc,
  output logic             Regrt,
  output logic             Se,
  output logic             Aluqb,
  output logic [1:0]       Aluc,
  output logic             Reg2reg,
  output logic             Wreg,
  output logic             Wmem,
  output logic             Instr_done,
  output logic [CNT_W-1:0] Icount,
  output logic             Illegal,
  output logic             Err,
  output logic [2:0]       State
);

  // The wait counter only needs to reach TIMEOUT-1: the TIMEOUT-th
  // rdy-less cycle is detected combinationally and aborts in that cycle.
  localparam int                WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e             r_state;
  state_e             w_next_state;
  logic [WAIT_W-1:0]  r_wait;
  dec_t               r_dec;        // class + decode fields latched at ID exit
  dec_t               w_id_dec;     // live decode of Op/Func
  dec_t               w_dec;        // decode view presented to the datapath
  logic [CNT_W-1:0]   r_icount;
  logic               r_illegal;
  logic               r_err;
  logic               w_waiting;
  logic               w_rdy;
  logic               w_expire;
  logic               w_set_ill;
  logic               w_set_err;

  instr_class_dec u_dec (
    .i_op   (Op),
    .i_func (Func),
    .o_dec  (w_id_dec)
  );

  // Handshake wait tracking: only IF and MEM ever wait on a memory.
  assign w_waiting = (r_state == ST_IF) || (r_state == ST_MEM);
  assign w_rdy     = (r_state == ST_IF) ? Imem_rdy : Dmem_rdy;
  // rdy arriving in the last allowed cycle wins over the timeout.
  assign w_expire  = w_waiting && !w_rdy && (r_wait == WAIT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_dec        = DEC_NONE;
    Imem_req     = 1'b0;
    Dmem_req     = 1'b0;
    Pcwr         = 1'b0;
    Irwr         = 1'b0;
    Pcsrc        = PCSRC_SEQ;
    Wreg         = 1'b0;
    Wmem         = 1'b0;
    Instr_done   = 1'b0;
    w_set_ill    = 1'b0;
    w_set_err    = 1'b0;

    case (r_state)
      ST_RST: w_next_state = ST_IF;

      ST_IF: begin
        Imem_req = 1'b1;
        if (Imem_rdy) begin
          Irwr         = 1'b1;
          Pcwr         = 1'b1;
          w_next_state = ST_ID;
        end else if (w_expire) begin
          // Abandon this fetch and retry with a fresh wait window.
          w_set_err = 1'b1;
        end
      end

      ST_ID: begin
        w_dec = w_id_dec;
        case (w_id_dec.cls)
          CLS_J: begin
            Pcwr         = 1'b1;
            Pcsrc        = PCSRC_JUMP;
            Instr_done   = 1'b1;
            w_next_state = ST_IF;
          end
          CLS_ILL: begin
            // Treated as a NOP: no strobes and it is not counted as retired.
            w_set_ill    = 1'b1;
            w_next_state = ST_IF;
          end
          default: w_next_state = ST_EX;
        endcase
      end

      ST_EX: begin
        w_dec = r_dec;
        case (r_dec.cls)
          CLS_BEQ, CLS_BNE: begin
            Pcwr         = (r_dec.cls == CLS_BEQ) ? Z : !Z;
            Pcsrc        = PCSRC_BRANCH;
            Instr_done   = 1'b1;
            w_next_state = ST_IF;
          end
          CLS_LW, CLS_SW:     w_next_state = ST_MEM;
          CLS_RALU, CLS_IALU: w_next_state = ST_WB;
          default:            w_next_state = ST_IF;
        endcase
      end

      ST_MEM: begin
        w_dec    = r_dec;
        Dmem_req = 1'b1;
        // The store enable is withdrawn on the cycle the access is abandoned.
        Wmem     = (r_dec.cls == CLS_SW) && !w_expire;
        if (Dmem_rdy) begin
          if (r_dec.cls == CLS_SW) begin
            Instr_done   = 1'b1;
            w_next_state = ST_IF;
          end else begin
            w_next_state = ST_WB;
          end
        end else if (w_expire) begin
          w_set_err    = 1'b1;
          w_next_state = ST_IF;
        end
      end

      ST_WB: begin
        w_dec        = r_dec;
        Wreg         = 1'b1;
        Instr_done   = 1'b1;
        w_next_state = ST_IF;
      end

      default: w_next_state = ST_RST;
    endcase
  end

  assign Regrt   = w_dec.regrt;
  assign Se      = w_dec.se;
  assign Aluqb   = w_dec.aluqb;
  assign Aluc    = w_dec.aluc;
  assign Reg2reg = w_dec.reg2reg;

  // ---------------------------------------------------------------------------
  // State, wait counter, latched decode, flags and retired count
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= ST_RST;
      r_wait    <= '0;
      r_dec     <= DEC_NONE;
      r_icount  <= '0;
      r_illegal <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next_state;

      // Counts consecutive rdy-less cycles; any rdy, abort or state change
      // starts the next wait from zero.
      if (w_waiting && !w_rdy && !w_expire) begin
        r_wait <= r_wait + WAIT_W'(1);
      end else begin
        r_wait <= '0;
      end

      if (r_state == ST_ID) begin
        r_dec <= w_id_dec;
      end

      if (Instr_done) begin
        r_icount <= r_icount + CNT_W'(1);
      end
      if (w_set_ill) begin
        r_illegal <= 1'b1;
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign State   = r_state;
  assign Icount  = r_icount;
  assign Illegal = r_illegal;
  assign Err     = r_err;

endmodule
